// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Owns the single register-file write port (we3/a3/wd3). The in-order pipeline
//   writeback normally takes the port. Multi-cycle (mul/div) results are queued
//   in a small FIFO and drained into idle slots. If the FIFO keeps losing the
//   port, pipe_hold forces a drain. A destination scoreboard flags pending
//   multi-cycle destinations to decode.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pipe_we/pipe_rd/pipe_wd    pipeline writeback request
//   mc_valid/mc_rd/mc_wd       multi-cycle result, accepted when mc_ready
//   mc_ready                   FIFO has room
//   issue_valid/issue_rd       multi-cycle op issued; marks issue_rd pending
//   rs1/rs2/rd                 decode-stage query addresses
//   hz_rs1/hz_rs2/hz_rd        query register still pending
//   pipe_hold                  pipeline must not write next cycle
//   we3/a3/wd3                 register-file write port
//   err                        sticky protocol-violation flag
module rf_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_wd,
    input  logic            mc_valid,
    input  logic [4:0]      mc_rd,
    input  logic [XLEN-1:0] mc_wd,
    output logic            mc_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    output logic            hz_rs1,
    output logic            hz_rs2,
    output logic            hz_rd,
    output logic            pipe_hold,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3,
    output logic            err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]      fifo_rd_q [DEPTH];
    logic [XLEN-1:0] fifo_wd_q [DEPTH];
    logic [4:0]      fifo_rd_d [DEPTH];
    logic [XLEN-1:0] fifo_wd_d [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          pipe_hold_q, pipe_hold_d;
    logic [31:0]   pending_q, pending_d;
    logic          err_q, err_d;

    logic fifo_ne, pipe_eff, pipe_take, push, pop, viol;

    assign mc_ready  = (count_q < CW'(DEPTH));
    assign pipe_hold = pipe_hold_q;
    assign err       = err_q;

    always_comb begin
        fifo_ne   = (count_q != '0);
        pipe_eff  = pipe_we && (pipe_rd != 5'd0);
        // A write attempted under hold is dropped; the FIFO head takes the slot.
        pipe_take = pipe_eff && !pipe_hold_q;
        pop       = fifo_ne && !pipe_take && !reset;
        push      = mc_valid && mc_ready && !reset;

        we3 = 1'b0;
        a3  = 5'd0;
        wd3 = '0;
        if (!reset) begin
            if (pop) begin
                we3 = 1'b1;
                a3  = fifo_rd_q[rd_ptr_q];
                wd3 = fifo_wd_q[rd_ptr_q];
            end else if (pipe_take) begin
                we3 = 1'b1;
                a3  = pipe_rd;
                wd3 = pipe_wd;
            end
        end
    end

    always_comb begin
        fifo_rd_d = fifo_rd_q;
        fifo_wd_d = fifo_wd_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q] = mc_rd;
            fifo_wd_d[wr_ptr_q] = mc_wd;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!fifo_ne || pop) begin
            starve_d = '0;
        end else if (pipe_take && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
        // Hold drops the cycle after the forced pop.
        pipe_hold_d = !pop && fifo_ne && (pipe_hold_q || (starve_q == SW'(STARVE_MAX)));
    end

    always_comb begin
        pending_d = pending_q;
        if (pop && (fifo_rd_q[rd_ptr_q] != 5'd0)) begin
            pending_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
        end
        // Applied after the clear so a same-cycle issue keeps the bit set.
        if (issue_valid && (issue_rd != 5'd0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        viol  = (issue_valid && (issue_rd != 5'd0) && pending_q[issue_rd])
              || (pipe_eff && pending_q[pipe_rd])
              || (pipe_eff && pipe_hold_q);
        err_d = err_q || viol;
    end

    // Masking on the committing write relies on the regfile's write-first bypass.
    always_comb begin
        hz_rs1 = (rs1 != 5'd0) && pending_q[rs1] && !(we3 && (a3 == rs1));
        hz_rs2 = (rs2 != 5'd0) && pending_q[rs2] && !(we3 && (a3 == rs2));
        hz_rd  = (rd  != 5'd0) && pending_q[rd]  && !(we3 && (a3 == rd));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            pipe_hold_q <= 1'b0;
            pending_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            pipe_hold_q <= pipe_hold_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says valid.
    always_ff @(posedge clk) begin
        fifo_rd_q <= fifo_rd_d;
        fifo_wd_q <= fifo_wd_d;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_wd;
    logic        mc_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1, rs2, rd;
    logic        hz_rs1, hz_rs2, hz_rd;
    logic        pipe_hold;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        err;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_wd(mc_wd), .mc_ready(mc_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_rd(hz_rd),
        .pipe_hold(pipe_hold), .we3(we3), .a3(a3), .wd3(wd3), .err(err)
    );

    typedef struct {
        logic        rst;
        logic        pwe;
        logic [4:0]  prd;
        logic [31:0] pwd;
        logic        mcv;
        logic [4:0]  mrd;
        logic [31:0] mwd;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  q1, q2, qd;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [6:0]  e_flags;  // {mc_ready, hz_rs1, hz_rs2, hz_rd, pipe_hold, err, 0}
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic add(input logic rst, input logic pwe, input logic [4:0] prd, input logic [31:0] pwd,
                       input logic mcv, input logic [4:0] mrd, input logic [31:0] mwd,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] qd,
                       input logic e_we, input logic [4:0] e_a3, input logic [31:0] e_wd,
                       input logic e_rdy, input logic e_h1, input logic e_h2, input logic e_hd,
                       input logic e_hold, input logic e_err);
        vec_t v;
        v.rst = rst; v.pwe = pwe; v.prd = prd; v.pwd = pwd;
        v.mcv = mcv; v.mrd = mrd; v.mwd = mwd; v.iv = iv; v.ird = ird;
        v.q1 = q1; v.q2 = q2; v.qd = qd;
        v.e_we = e_we; v.e_a3 = e_a3; v.e_wd = e_wd;
        v.e_flags = {e_rdy, e_h1, e_h2, e_hd, e_hold, e_err, 1'b0};
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; pipe_we = v.pwe; pipe_rd = v.prd; pipe_wd = v.pwd;
        mc_valid = v.mcv; mc_rd = v.mrd; mc_wd = v.mwd;
        issue_valid = v.iv; issue_rd = v.ird;
        rs1 = v.q1; rs2 = v.q2; rd = v.qd;
    endtask

    task automatic check(input string name, input logic ok, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; pipe_we = 1'b0; pipe_rd = 5'd0; pipe_wd = '0;
        mc_valid = 1'b0; mc_rd = 5'd0; mc_wd = '0;
        issue_valid = 1'b0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    endtask

    initial begin
        logic [6:0]  got_flags;
        logic [37:0] got_port, exp_port;
        int          n;
        logic        found;
        logic        hold_at_pop;

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // idle port: one mc result drains the cycle after acceptance
        add(0, 0,0,0,       0,0,0,            0,0,  5,0,0,  0,0,0,            1,0,0,0,0,0);
        add(0, 0,0,0,       1,5,32'hDEADBEEF, 0,0,  5,0,0,  0,0,0,            1,0,0,0,0,0);
        add(0, 0,0,0,       0,0,0,            0,0,  5,0,0,  1,5,32'hDEADBEEF, 1,0,0,0,0,0);
        add(0, 0,0,0,       0,0,0,            0,0,  5,0,0,  0,0,0,            1,0,0,0,0,0);
        // pipe priority, FIFO fill, starvation hold, dropped push while full
        add(0, 1,7,32'h77,  1,3,32'h33,       0,0,  0,0,0,  1,7,32'h77,       1,0,0,0,0,0);
        add(0, 1,7,32'h77,  1,4,32'h44,       0,0,  0,0,0,  1,7,32'h77,       1,0,0,0,0,0);
        for (int i = 0; i < 4; i++)
            add(0, 1,7,32'h77, 0,0,0,         0,0,  0,0,0,  1,7,32'h77,       0,0,0,0,0,0);
        add(0, 1,7,32'h77,  1,20,32'h2020,    0,0,  0,0,0,  1,3,32'h33,       0,0,0,0,1,0);
        add(0, 1,7,32'h77,  0,0,0,            0,0,  0,0,0,  1,7,32'h77,       1,0,0,0,0,1);
        add(0, 0,0,0,       0,0,0,            0,0,  0,0,0,  1,4,32'h44,       1,0,0,0,0,1);
        add(0, 0,0,0,       0,0,0,            0,0,  0,0,0,  0,0,0,            1,0,0,0,0,1);
        add(1, 0,0,0,       0,0,0,            0,0,  0,0,0,  0,0,0,            1,0,0,0,0,1);
        // scoreboard set, hazard, commit clears
        add(0, 0,0,0,       0,0,0,            1,9,  9,0,0,  0,0,0,            1,0,0,0,0,0);
        add(0, 0,0,0,       0,0,0,            0,0,  9,0,0,  0,0,0,            1,1,0,0,0,0);
        add(0, 0,0,0,       1,9,32'h99,       0,0,  9,0,0,  0,0,0,            1,1,0,0,0,0);
        add(0, 0,0,0,       0,0,0,            0,0,  9,0,0,  1,9,32'h99,       1,0,0,0,0,0);
        add(0, 0,0,0,       0,0,0,            0,0,  9,0,0,  0,0,0,            1,0,0,0,0,0);
        // set wins over same-cycle clear (re-issue to pending rd also flags err)
        add(0, 0,0,0,       0,0,0,            1,9,  0,0,9,  0,0,0,            1,0,0,0,0,0);
        add(0, 0,0,0,       1,9,32'hA9,       0,0,  0,0,9,  0,0,0,            1,0,0,1,0,0);
        add(0, 0,0,0,       0,0,0,            1,9,  0,0,9,  1,9,32'hA9,       1,0,0,0,0,0);
        add(0, 0,0,0,       0,0,0,            0,0,  0,0,9,  0,0,0,            1,0,0,1,0,1);
        add(1, 0,0,0,       0,0,0,            0,0,  0,0,0,  0,0,0,            1,0,0,0,0,1);
        // WAW violation: pipe write to pending rd proceeds, err sticky
        add(0, 0,0,0,       0,0,0,            1,9,  0,0,9,  0,0,0,            1,0,0,0,0,0);
        add(0, 1,9,32'h5A,  0,0,0,            0,0,  0,0,9,  1,9,32'h5A,       1,0,0,0,0,0);
        for (int i = 0; i < 10; i++)
            add(0, 0,0,0,   0,0,0,            0,0,  0,0,9,  0,0,0,            1,0,0,1,0,1);
        add(1, 0,0,0,       0,0,0,            0,0,  0,0,0,  0,0,0,            1,0,0,0,0,1);
        // hold violation: pipe write under hold is dropped, head written
        add(0, 1,7,32'h77,  1,3,32'h33,       0,0,  0,0,0,  1,7,32'h77,       1,0,0,0,0,0);
        for (int i = 0; i < 5; i++)
            add(0, 1,7,32'h77, 0,0,0,         0,0,  0,0,0,  1,7,32'h77,       1,0,0,0,0,0);
        add(0, 1,7,32'h77,  0,0,0,            0,0,  0,0,0,  1,3,32'h33,       1,0,0,0,1,0);
        add(0, 1,7,32'h77,  0,0,0,            0,0,  0,0,0,  1,7,32'h77,       1,0,0,0,0,1);
        add(1, 0,0,0,       0,0,0,            0,0,  0,0,0,  0,0,0,            1,0,0,0,0,1);
        // x0 pipe write never occupies the port; mc entry to x0 still writes
        add(0, 1,0,32'hFF,  1,6,32'h66,       0,0,  0,0,0,  0,0,0,            1,0,0,0,0,0);
        add(0, 1,0,32'hFF,  0,0,0,            0,0,  0,0,0,  1,6,32'h66,       1,0,0,0,0,0);
        add(0, 0,0,0,       0,0,0,            0,0,  0,0,0,  0,0,0,            1,0,0,0,0,0);
        add(0, 0,0,0,       1,0,32'h10,       0,0,  0,0,0,  0,0,0,            1,0,0,0,0,0);
        add(0, 0,0,0,       0,0,0,            0,0,  0,0,0,  1,0,32'h10,       1,0,0,0,0,0);
        // reset with two entries queued and a pending destination
        add(0, 1,7,32'h77,  1,11,32'hB1,      1,12, 0,0,0,  1,7,32'h77,       1,0,0,0,0,0);
        add(0, 1,7,32'h77,  1,13,32'hB3,      0,0,  0,0,0,  1,7,32'h77,       1,0,0,0,0,0);
        add(1, 1,7,32'h77,  0,0,0,            0,0,  12,11,13, 0,0,0,          0,1,0,0,0,0);
        add(0, 0,0,0,       0,0,0,            0,0,  12,11,13, 0,0,0,          1,0,0,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            got_flags = {mc_ready, hz_rs1, hz_rs2, hz_rd, pipe_hold, err, 1'b0};
            got_port  = {we3, a3, wd3};
            exp_port  = {vecs[i].e_we, vecs[i].e_a3, vecs[i].e_wd};
            n_total++;
            if (got_port === exp_port && got_flags === vecs[i].e_flags) begin
                n_pass++;
            end else begin
                $display("FAIL vec[%0d]: got we3=%0b a3=%0d wd3=%h flags=%b, expected we3=%0b a3=%0d wd3=%h flags=%b",
                         i, we3, a3, wd3, got_flags, vecs[i].e_we, vecs[i].e_a3, vecs[i].e_wd, vecs[i].e_flags);
            end
            @(posedge clk);
            #1;
        end

        // Starvation latency: a lone entry under continuous pipe writes drains
        // on the 6th cycle after acceptance (4 lost slots saturate, hold, pop).
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        pipe_we = 1'b1; pipe_rd = 5'd7; pipe_wd = 32'h77;
        mc_valid = 1'b1; mc_rd = 5'd15; mc_wd = 32'hF00D;
        @(posedge clk); #1;
        mc_valid = 1'b0;
        n = 0; found = 1'b0; hold_at_pop = 1'b0;
        while (!found && n < 20) begin
            @(negedge clk);
            n++;
            if (we3 && a3 == 5'd15) begin
                found = 1'b1;
                hold_at_pop = pipe_hold;
                check("starve_wd3", wd3 === 32'hF00D, 64'(wd3), 64'h0000F00D);
            end
            @(posedge clk); #1;
        end
        check("starve_latency", found && n == 6, 64'(n), 64'd6);
        check("starve_hold", hold_at_pop === 1'b1, 64'(hold_at_pop), 64'd1);
        @(negedge clk);
        check("hold_viol_err", err === 1'b1, 64'(err), 64'd1);
        check("hold_released", pipe_hold === 1'b0, 64'(pipe_hold), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
